// File: rtl/srp_pkg.sv
// srp_pkg: shared types and sizes for the SRP sync-buffer capture path.
package srp_pkg;

    localparam int SRP_DEPTH = 2096;
    localparam int SRP_AW    = 12;
    localparam int SRP_DW    = 32;

    typedef enum logic [1:0] {
        CAPTURE,
        POST,
        HOLD,
        READOUT
    } srp_state_e;

endpackage

// File: rtl/srp_out_fifo2.sv
// srp_out_fifo2: two-entry output FIFO; the writer uses count to
// avoid pushing when full, the reader sees a valid/ready head.
module srp_out_fifo2
    import srp_pkg::*;
#(
    parameter int DW = SRP_DW
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_valid,
    output logic signed [DW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           count
);

    logic signed [DW-1:0] mem [2];
    logic wp;
    logic rp;
    logic push;
    logic pop;

    assign push      = in_valid;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rp];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= in_data;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/srp_capture_sequencer.sv
// srp_capture_sequencer: circular pre/post-trigger capture into the sync
// BRAM, then oldest-first valid/ready replay of the captured window.
module srp_capture_sequencer
    import srp_pkg::*;
#(
    parameter int DEPTH    = SRP_DEPTH,
    parameter int AW       = SRP_AW,
    parameter int DW       = SRP_DW,
    parameter int POST_LEN = 512
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 sync_trig,
    input  logic                 rd_start,
    output logic                 bram_en,
    output logic                 bram_we,
    output logic [AW-1:0]        bram_addr,
    output logic signed [DW-1:0] bram_di,
    input  logic signed [DW-1:0] bram_dout,
    output logic signed [DW-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 s_drop
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   POST_C  = (AW+1)'(POST_LEN);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    srp_state_e state;
    srp_state_e state_n;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   fill;
    logic [AW:0]   post_cnt;
    logic [AW:0]   rd_iss;
    logic [AW:0]   rd_cnt;
    logic          inflight;
    logic          wr_go;
    logic          rd_go;
    logic          pop;
    logic [1:0]    occ;
    logic [2:0]    slots;

    assign wr_go  = s_valid && (state == CAPTURE || state == POST);
    assign pop    = m_valid && m_ready;
    assign busy   = (state != CAPTURE);
    assign m_last = m_valid && (rd_cnt == fill - 1'b1);
    // the head leaving this cycle frees its slot, so a steady stream never bubbles
    assign slots  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        state_n   = state;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_di   = '0;
        rd_go     = 1'b0;
        s_drop    = 1'b0;
        unique case (state)
            CAPTURE: begin
                if (sync_trig) begin
                    state_n = (POST_LEN == 0) ? HOLD : POST;
                end
            end
            POST: begin
                if (s_valid && post_cnt == POST_C - 1'b1) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                s_drop = s_valid;
                if (rd_start) begin
                    state_n = (fill == '0) ? CAPTURE : READOUT;
                end
            end
            READOUT: begin
                s_drop = s_valid;
                rd_go  = (rd_iss < fill) && (slots < 3'd2);
                if (pop && m_last) begin
                    state_n = CAPTURE;
                end
            end
            default: state_n = CAPTURE;
        endcase
        if (wr_go) begin
            bram_en   = 1'b1;
            bram_we   = 1'b1;
            bram_addr = wr_ptr;
            bram_di   = s_data;
        end else if (rd_go) begin
            bram_en   = 1'b1;
            bram_addr = rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= CAPTURE;
            wr_ptr   <= '0;
            rd_addr  <= '0;
            fill     <= '0;
            post_cnt <= '0;
            rd_iss   <= '0;
            rd_cnt   <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_n;
            inflight <= rd_go;
            if (wr_go) begin
                wr_ptr <= (wr_ptr == LAST_A) ? '0 : wr_ptr + 1'b1;
                if (fill != DEPTH_C) begin
                    fill <= fill + 1'b1;
                end
            end
            if (state == CAPTURE && sync_trig) begin
                post_cnt <= '0;
            end else if (state == POST && s_valid) begin
                post_cnt <= post_cnt + 1'b1;
            end
            if (state == HOLD && rd_start) begin
                rd_addr <= (fill == DEPTH_C) ? wr_ptr : '0;
                rd_iss  <= '0;
                rd_cnt  <= '0;
            end
            if (rd_go) begin
                rd_addr <= (rd_addr == LAST_A) ? '0 : rd_addr + 1'b1;
                rd_iss  <= rd_iss + 1'b1;
            end
            if (pop) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            // a finished replay reopens the buffer empty
            if (state != CAPTURE && state_n == CAPTURE) begin
                wr_ptr <= '0;
                fill   <= '0;
            end
        end
    end

    srp_out_fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (bram_dout),
        .in_valid (inflight),
        .out_data (m_data),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .count    (occ)
    );

endmodule

// File: tb/tb_srp_capture_sequencer.sv
// Bench: two sequencers (POST_LEN 0 and 50) share stimulus; a window model
// predicts writes/drops and a scoreboard checks the replayed streams.
module tb_srp_capture_sequencer;
    import srp_pkg::*;

    localparam int DEPTH = 2096;
    localparam int AW    = 12;
    localparam int DW    = 32;

    typedef logic signed [DW-1:0] smp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    smp_t s_data = '0;
    logic s_valid = 1'b0;
    logic sync_trig = 1'b0;
    logic rd_start = 1'b0;
    logic m_ready = 1'b1;

    logic          bram_en   [2];
    logic          bram_we   [2];
    logic [AW-1:0] bram_addr [2];
    smp_t          bram_di   [2];
    smp_t          m_data    [2];
    logic          m_valid   [2];
    logic          m_last    [2];
    logic          busy      [2];
    logic          s_drop    [2];

    int checks = 0;
    int passes = 0;
    int rdy_mode = 0;

    // model: 0 capture, 1 post, 2 hold, 3 readout
    int   phase [2];
    int   wcnt  [2];
    int   pcnt  [2];
    smp_t hist  [2][$];
    smp_t expq  [2][$];

    always #5 clk = ~clk;

    function automatic int plen(int i);
        return (i == 0) ? 0 : 50;
    endfunction

    task automatic chk(string nm, int i, longint act, longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s[%0d]: got %0d, expected %0d", nm, i, act, exp);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g
        smp_t dout;
        smp_t mem [DEPTH];
        smp_t e;
        smp_t prev_data;
        bit   prev_hold = 0;
        bit   prev_xfer = 0;
        bit   prev_last = 0;

        srp_capture_sequencer #(
            .DEPTH(DEPTH), .AW(AW), .DW(DW), .POST_LEN(gi == 0 ? 0 : 50)
        ) u_dut (
            .clk      (clk),
            .rstn     (rstn),
            .s_data   (s_data),
            .s_valid  (s_valid),
            .sync_trig(sync_trig),
            .rd_start (rd_start),
            .bram_en  (bram_en[gi]),
            .bram_we  (bram_we[gi]),
            .bram_addr(bram_addr[gi]),
            .bram_di  (bram_di[gi]),
            .bram_dout(dout),
            .m_data   (m_data[gi]),
            .m_valid  (m_valid[gi]),
            .m_ready  (m_ready),
            .m_last   (m_last[gi]),
            .busy     (busy[gi]),
            .s_drop   (s_drop[gi])
        );

        always @(posedge clk) begin
            if (bram_en[gi]) begin
                if (bram_we[gi]) mem[bram_addr[gi]] <= bram_di[gi];
                else dout <= mem[bram_addr[gi]];
            end
        end

        always @(negedge clk) begin
            if (!rstn) begin
                prev_hold = 0;
                prev_xfer = 0;
                prev_last = 0;
            end else begin
                if (prev_hold) begin
                    chk("stall_valid", gi, m_valid[gi], 1);
                    chk("stall_data", gi, m_data[gi], prev_data);
                end
                if (prev_xfer && !prev_last && rdy_mode == 0)
                    chk("full_rate", gi, m_valid[gi], 1);
                if (m_valid[gi] && m_ready) begin
                    if (expq[gi].size() == 0) begin
                        checks++;
                        $display("FAIL spurious_out[%0d]: got data %0d, expected no output",
                                 gi, m_data[gi]);
                    end else begin
                        e = expq[gi].pop_front();
                        chk("m_data", gi, m_data[gi], e);
                        chk("m_last", gi, m_last[gi], expq[gi].size() == 0);
                        if (expq[gi].size() == 0 && phase[gi] == 3) begin
                            phase[gi] = 0;
                            wcnt[gi] = 0;
                            hist[gi].delete();
                        end
                    end
                end
                prev_hold = m_valid[gi] && !m_ready;
                prev_xfer = m_valid[gi] && m_ready;
                prev_last = m_last[gi];
                prev_data = m_data[gi];
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            phase[i] = 0;
            wcnt[i] = 0;
            pcnt[i] = 0;
            hist[i].delete();
            expq[i].delete();
        end
    endtask

    task automatic write(int i, smp_t d);
        hist[i].push_back(d);
        if (hist[i].size() > DEPTH) void'(hist[i].pop_front());
        wcnt[i]++;
    endtask

    task automatic step(bit sv, smp_t d, bit tr, bit rs);
        @(posedge clk);
        #1;
        s_valid = sv;
        s_data = d;
        sync_trig = tr;
        rd_start = rs;
        m_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("busy", i, busy[i], phase[i] != 0);
            if (phase[i] >= 2) begin
                chk("s_drop", i, s_drop[i], sv);
                if (phase[i] == 2) chk("hold_en", i, bram_en[i], 0);
            end else begin
                chk("s_drop", i, s_drop[i], 0);
                chk("wr_en", i, bram_en[i], sv);
                if (sv) begin
                    chk("wr_we", i, bram_we[i], 1);
                    chk("wr_addr", i, bram_addr[i], wcnt[i] % DEPTH);
                    chk("wr_di", i, bram_di[i], d);
                end
            end
            case (phase[i])
                0: begin
                    if (sv) write(i, d);
                    if (tr) begin
                        pcnt[i] = 0;
                        phase[i] = (plen(i) == 0) ? 2 : 1;
                    end
                end
                1: begin
                    if (sv) begin
                        write(i, d);
                        pcnt[i]++;
                        if (pcnt[i] == plen(i)) phase[i] = 2;
                    end
                end
                2: begin
                    if (rs) begin
                        if (hist[i].size() == 0) begin
                            phase[i] = 0;
                        end else begin
                            foreach (hist[i][k]) expq[i].push_back(hist[i][k]);
                            phase[i] = 3;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((phase[0] == 3 || phase[1] == 3) && n < budget) begin
            step(1'b0, '0, 1'b0, 1'b0);
            n++;
        end
        if (phase[0] == 3 || phase[1] == 3) begin
            checks++;
            $display("FAIL readout_timeout: still replaying after %0d cycles, expected done",
                     budget);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_en", i, bram_en[i], 0);
            chk("rst_we", i, bram_we[i], 0);
            chk("rst_addr", i, bram_addr[i], 0);
            chk("rst_di", i, bram_di[i], 0);
            chk("rst_m_valid", i, m_valid[i], 0);
            chk("rst_m_last", i, m_last[i], 0);
            chk("rst_m_data", i, m_data[i], 0);
            chk("rst_busy", i, busy[i], 0);
            chk("rst_drop", i, s_drop[i], 0);
        end
        rstn = 1'b1;

        // ramp 0..99, trigger on 49, full-rate readout
        rdy_mode = 0;
        for (int k = 0; k < 100; k++) step(1'b1, smp_t'(k), k == 49, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        wait_idle(500);

        // long ramp wrapping the buffer, stalling readout
        rdy_mode = 1;
        for (int k = 0; k < 3096; k++) step(1'b1, smp_t'(k), k == 3045, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        wait_idle(20000);

        // trigger with a sample, extra sample and retrigger in HOLD
        rdy_mode = 0;
        step(1'b1, smp_t'(7), 1'b1, 1'b0);
        step(1'b1, smp_t'(8), 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        wait_idle(100);
        for (int k = 0; k < 49; k++) step(1'b1, smp_t'(100 + k), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        wait_idle(500);

        // empty capture, then a short second capture
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b1, smp_t'(500 + k), k == 9, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b1, smp_t'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        wait_idle(500);

        // random traffic
        rdy_mode = 1;
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 3) != 0, smp_t'($urandom),
                 $urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0);
        for (int n = 0; n < 300 && (phase[0] == 1 || phase[1] == 1); n++)
            step(1'b1, smp_t'($urandom), 1'b0, 1'b0);
        wait_idle(20000);
        step(1'b0, '0, 1'b0, 1'b1);
        wait_idle(20000);
        for (int i = 0; i < 2; i++) chk("drained", i, expq[i].size(), 0);

        // reset in the middle of a readout
        rdy_mode = 0;
        for (int k = 0; k < 200; k++) step(1'b1, smp_t'(k), k == 100, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        repeat (20) step(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_mid_valid", i, m_valid[i], 0);
            chk("rst_mid_busy", i, busy[i], 0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b1, smp_t'(42), 1'b0, 1'b0);
        step(1'b1, smp_t'(43), 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
